// File: rtl/alu_pkg.sv
// alu_pkg: op codes, flag bit positions, response-buffer state type and the
// op-code legality check shared by the ALU, the arbiter and the bench.
package alu_pkg;

   localparam logic [2:0] ALU_PASSB = 3'b000;
   localparam logic [2:0] ALU_ADD   = 3'b010;
   localparam logic [2:0] ALU_SUB   = 3'b011;
   localparam logic [2:0] ALU_AND   = 3'b100;
   localparam logic [2:0] ALU_OR    = 3'b101;
   localparam logic [2:0] ALU_XOR   = 3'b110;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_V = 1;
   localparam int FLAG_C = 0;

   typedef enum logic {
      RSP_EMPTY = 1'b0,
      RSP_FULL  = 1'b1
   } rsp_state_e;

   // 001 and 111 are unassigned encodings.
   function automatic logic op_legal(input logic [2:0] cntrl);
      return (cntrl != 3'b001) && (cntrl != 3'b111);
   endfunction

endpackage

// File: rtl/alu_64bit.sv
// alu_64bit: combinational 64-bit ripple-carry ALU.
//   a, b    : operands
//   cntrl   : op code (alu_pkg ALU_*)
//   result  : op result (0 for illegal codes)
//   flags   : {negative, zero, overflow, carry_out}
module alu_64bit
   import alu_pkg::*;
(
   input  logic [63:0] a,
   input  logic [63:0] b,
   input  logic [2:0]  cntrl,
   output logic [63:0] result,
   output logic [3:0]  flags
);

   logic [63:0] bx;
   logic [63:0] sum;
   logic        c;
   logic        c_msb;
   logic        sub;

   // One adder serves ADD and SUB (A + ~B + 1). Carry/overflow always come
   // from this adder, so for logic ops they are the raw adder values.
   // Carry is not inverted for SUB: carry_out=1 means no borrow.
   always_comb begin
      sub   = (cntrl == ALU_SUB);
      bx    = sub ? ~b : b;
      sum   = '0;
      c     = sub;
      c_msb = 1'b0;
      for (int i = 0; i < 64; i++) begin
         if (i == 63) c_msb = c;
         sum[i] = a[i] ^ bx[i] ^ c;
         c      = (a[i] & bx[i]) | (c & (a[i] ^ bx[i]));
      end
   end

   always_comb begin
      case (cntrl)
         ALU_PASSB:        result = b;
         ALU_ADD, ALU_SUB: result = sum;
         ALU_AND:          result = a & b;
         ALU_OR:           result = a | b;
         ALU_XOR:          result = a ^ b;
         default:          result = '0;
      endcase
      flags         = '0;
      flags[FLAG_N] = result[63];
      flags[FLAG_Z] = (result == '0);
      flags[FLAG_V] = c_msb ^ c;
      flags[FLAG_C] = c;
   end

endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot arbiter with its own priority pointer.
//   clk, reset : clock, synchronous active-high reset
//   req_valid  : per-requester request
//   en         : grant allowed this cycle
//   gnt        : one-hot grant (combinational)
//   gnt_idx    : index of granted requester
//   gnt_any    : a grant is issued
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [NREQ-1:0] req_valid,
   input  logic            en,
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  gnt_idx,
   output logic            gnt_any
);

   logic [IDW-1:0] ptr_q, ptr_d;
   int             idx;

   // Search ptr, ptr+1, ... wrapping; first valid wins. Reset blocks grants
   // so nothing is accepted in the reset cycle.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      idx     = 0;
      if (en && !reset) begin
         for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (!gnt_any && req_valid[idx]) begin
               gnt_any = 1'b1;
               gnt_idx = IDW'(idx);
            end
         end
      end
      if (gnt_any) gnt[gnt_idx] = 1'b1;
   end

   always_comb begin
      ptr_d = ptr_q;
      if (gnt_any)
         ptr_d = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) ptr_q <= '0;
      else       ptr_q <= ptr_d;
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one alu_64bit among NREQ requesters.
//   req_valid/req_ready : per-requester handshake, req_ready one-hot, comb
//   req_a/req_b         : 64-bit operands, requester i at [64*i +: 64]
//   req_cntrl           : op code, requester i at [3*i +: 3]
//   rsp_valid/rsp_ready : one-entry registered response buffer handshake
//   rsp_id              : owner of the buffered response
//   rsp_result/rsp_flags: ALU result and {N,Z,V,C}
//   rsp_err             : accepted op code was illegal
module alu_share_arbiter
   import alu_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NREQ-1:0]    req_valid,
   input  logic [NREQ*64-1:0] req_a,
   input  logic [NREQ*64-1:0] req_b,
   input  logic [NREQ*3-1:0]  req_cntrl,
   output logic [NREQ-1:0]    req_ready,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [IDW-1:0]     rsp_id,
   output logic [63:0]        rsp_result,
   output logic [3:0]         rsp_flags,
   output logic               rsp_err
);

   rsp_state_e     state_q, state_d;
   logic [IDW-1:0] rsp_id_q, rsp_id_d;
   logic [63:0]    rsp_result_q, rsp_result_d;
   logic [3:0]     rsp_flags_q, rsp_flags_d;
   logic           rsp_err_q, rsp_err_d;

   logic           can_issue;
   logic [IDW-1:0] gnt_idx;
   logic           gnt_any;
   logic [63:0]    alu_a, alu_b, alu_res;
   logic [2:0]     alu_cntrl;
   logic [3:0]     alu_flags;

   // A full buffer being popped this cycle can be refilled in the same edge.
   assign can_issue = (state_q == RSP_EMPTY) || rsp_ready;

   rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .en        (can_issue),
      .gnt       (req_ready),
      .gnt_idx   (gnt_idx),
      .gnt_any   (gnt_any)
   );

   // Idle ALU sees zeros so it does not toggle on unselected requesters.
   always_comb begin
      alu_a     = '0;
      alu_b     = '0;
      alu_cntrl = ALU_PASSB;
      if (gnt_any) begin
         alu_a     = req_a[64*int'(gnt_idx) +: 64];
         alu_b     = req_b[64*int'(gnt_idx) +: 64];
         alu_cntrl = req_cntrl[3*int'(gnt_idx) +: 3];
      end
   end

   alu_64bit u_alu (
      .a      (alu_a),
      .b      (alu_b),
      .cntrl  (alu_cntrl),
      .result (alu_res),
      .flags  (alu_flags)
   );

   always_comb begin
      state_d      = state_q;
      rsp_id_d     = rsp_id_q;
      rsp_result_d = rsp_result_q;
      rsp_flags_d  = rsp_flags_q;
      rsp_err_d    = rsp_err_q;
      if (gnt_any) begin
         state_d  = RSP_FULL;
         rsp_id_d = gnt_idx;
         if (op_legal(alu_cntrl)) begin
            rsp_result_d = alu_res;
            rsp_flags_d  = alu_flags;
            rsp_err_d    = 1'b0;
         end else begin
            rsp_result_d = '0;
            rsp_flags_d  = '0;
            rsp_err_d    = 1'b1;
         end
      end else if (state_q == RSP_FULL && rsp_ready) begin
         // Pop only: payload holds, just mark empty.
         state_d = RSP_EMPTY;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= RSP_EMPTY;
         rsp_id_q     <= '0;
         rsp_result_q <= '0;
         rsp_flags_q  <= '0;
         rsp_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         rsp_id_q     <= rsp_id_d;
         rsp_result_q <= rsp_result_d;
         rsp_flags_q  <= rsp_flags_d;
         rsp_err_q    <= rsp_err_d;
      end
   end

   assign rsp_valid  = (state_q == RSP_FULL);
   assign rsp_id     = rsp_id_q;
   assign rsp_result = rsp_result_q;
   assign rsp_flags  = rsp_flags_q;
   assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter (NREQ=4). Inputs change 1 ns after a
// rising edge; outputs are sampled 2 ns after the edge.
module tb_alu_share_arbiter;

   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic               clk = 1'b0;
   logic               reset;
   logic [NREQ-1:0]    req_valid;
   logic [NREQ*64-1:0] req_a;
   logic [NREQ*64-1:0] req_b;
   logic [NREQ*3-1:0]  req_cntrl;
   logic [NREQ-1:0]    req_ready;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [IDW-1:0]     rsp_id;
   logic [63:0]        rsp_result;
   logic [3:0]         rsp_flags;
   logic               rsp_err;

   int checks = 0;
   int errors = 0;

   always #25 clk = ~clk;

   alu_share_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_cntrl  (req_cntrl),
      .req_ready  (req_ready),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_result (rsp_result),
      .rsp_flags  (rsp_flags),
      .rsp_err    (rsp_err)
   );

   // Advance past the next rising edge; leaves time at edge+1.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [63:0] a,
                          input logic [63:0] b, input logic [2:0] c);
      req_a[64*i +: 64] = a;
      req_b[64*i +: 64] = b;
      req_cntrl[3*i +: 3] = c;
   endtask

   task automatic test_reset();
      reset = 1'b1; rsp_ready = 1'b1; req_valid = 4'b1111;
      #1;
      checks++;
      if (req_ready !== 4'b0000) begin
         errors++; $display("FAIL reset_ready got %b exp 0000", req_ready);
      end
      step(); step();
      #1;
      checks++;
      if ({rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err} !== '0) begin
         errors++;
         $display("FAIL reset_vals got v=%b id=%0d r=%h f=%b e=%b exp all 0",
                  rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err);
      end
      req_valid = '0;
      reset = 1'b0;
      step();
   endtask

   task automatic test_single_op();
      rsp_ready = 1'b0;
      set_req(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 3'b010);
      req_valid = 4'b0001;
      #1;
      checks++;
      if (req_ready !== 4'b0001) begin
         errors++; $display("FAIL single_ready got %b exp 0001", req_ready);
      end
      step();
      req_valid = '0;
      #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_err !== 1'b0 ||
          rsp_result !== 64'h8000_0000_0000_0000 || rsp_flags !== 4'b1010) begin
         errors++;
         $display("FAIL single_rsp got v=%b id=%0d r=%h f=%b e=%b exp 1 0 8000000000000000 1010 0",
                  rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err);
      end
      rsp_ready = 1'b1;
      step();
      #1;
      checks++;
      if (rsp_valid !== 1'b0 || rsp_result !== 64'h8000_0000_0000_0000) begin
         errors++;
         $display("FAIL single_pop got v=%b r=%h exp 0 8000000000000000",
                  rsp_valid, rsp_result);
      end
   endtask

   // Starts from a reset so the pointer is 0.
   task automatic test_round_robin();
      logic [3:0] exp_rdy;
      reset = 1'b1; step(); reset = 1'b0;
      rsp_ready = 1'b1;
      for (int i = 0; i < NREQ; i++) set_req(i, 64'(i + 1), 64'd10, 3'b010);
      req_valid = 4'b1111;
      for (int c = 0; c < 5; c++) begin
         exp_rdy = 4'b0001 << (c % 4);
         #1;
         checks++;
         if (req_ready !== exp_rdy) begin
            errors++; $display("FAIL rr_ready[%0d] got %b exp %b", c, req_ready, exp_rdy);
         end
         step();
         #1;
         checks++;
         if (rsp_valid !== 1'b1 || rsp_id !== 2'(c % 4) ||
             rsp_result !== 64'((c % 4) + 11)) begin
            errors++;
            $display("FAIL rr_rsp[%0d] got v=%b id=%0d r=%0d exp 1 %0d %0d",
                     c, rsp_valid, rsp_id, rsp_result, c % 4, (c % 4) + 11);
         end
      end
      req_valid = '0;
      step();
      #1;
      checks++;
      if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_result !== 64'd11) begin
         errors++;
         $display("FAIL rr_drain got v=%b id=%0d r=%0d exp 0 0 11",
                  rsp_valid, rsp_id, rsp_result);
      end
   endtask

   // Pointer is 1 on entry.
   task automatic test_backpressure();
      rsp_ready = 1'b0;
      set_req(0, 64'd40, 64'd2, 3'b010);
      req_valid = 4'b0001;
      step();                                   // fills with id 0, ptr -> 1
      set_req(1, 64'd100, 64'd1, 3'b010);
      set_req(2, 64'd5, 64'd3, 3'b011);
      req_valid = 4'b0110;
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++;
         if (req_ready !== 4'b0000 || rsp_valid !== 1'b1 || rsp_id !== 2'd0 ||
             rsp_result !== 64'd42) begin
            errors++;
            $display("FAIL bp_hold[%0d] got rdy=%b v=%b id=%0d r=%0d exp 0000 1 0 42",
                     c, req_ready, rsp_valid, rsp_id, rsp_result);
         end
         step();
      end
      rsp_ready = 1'b1;
      #1;
      checks++;
      if (req_ready !== 4'b0010) begin
         errors++; $display("FAIL bp_grant1 got %b exp 0010", req_ready);
      end
      step();
      req_valid = 4'b0100;
      #1;
      checks++;
      if (rsp_id !== 2'd1 || rsp_result !== 64'd101 || req_ready !== 4'b0100) begin
         errors++;
         $display("FAIL bp_rsp1 got id=%0d r=%0d rdy=%b exp 1 101 0100",
                  rsp_id, rsp_result, req_ready);
      end
      step();
      req_valid = '0;
      #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_result !== 64'd2) begin
         errors++;
         $display("FAIL bp_rsp2 got v=%b id=%0d r=%0d exp 1 2 2",
                  rsp_valid, rsp_id, rsp_result);
      end
      step();
   endtask

   task automatic test_flags();
      rsp_ready = 1'b1;
      set_req(3, 64'd4, 64'd5, 3'b011);
      req_valid = 4'b1000;
      step();
      set_req(3, 64'd10, 64'd10, 3'b011);
      #1;
      checks++;
      if (rsp_id !== 2'd3 || rsp_result !== 64'hFFFF_FFFF_FFFF_FFFF || rsp_flags !== 4'b1000) begin
         errors++;
         $display("FAIL flags_sub_neg got id=%0d r=%h f=%b exp 3 ffffffffffffffff 1000",
                  rsp_id, rsp_result, rsp_flags);
      end
      step();
      req_valid = '0;
      #1;
      checks++;
      if (rsp_result !== 64'd0 || rsp_flags !== 4'b0101) begin
         errors++;
         $display("FAIL flags_sub_zero got r=%h f=%b exp 0 0101", rsp_result, rsp_flags);
      end
      set_req(0, 64'hF0F0, 64'hFF00, 3'b100);
      req_valid = 4'b0001;
      step();
      req_valid = '0;
      #1;
      checks++;
      if (rsp_id !== 2'd0 || rsp_result !== 64'hF000 || rsp_flags !== 4'b0000) begin
         errors++;
         $display("FAIL flags_and got id=%0d r=%h f=%b exp 0 f000 0000",
                  rsp_id, rsp_result, rsp_flags);
      end
      step();
   endtask

   task automatic test_illegal();
      rsp_ready = 1'b1;
      set_req(3, 64'd5, 64'd6, 3'b111);
      req_valid = 4'b1000;
      step();
      set_req(3, 64'd5, 64'd6, 3'b010);
      set_req(0, 64'd1, 64'd1, 3'b010);
      req_valid = 4'b1001;
      #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_err !== 1'b1 ||
          rsp_result !== 64'd0 || rsp_flags !== 4'b0000) begin
         errors++;
         $display("FAIL illegal_rsp got v=%b id=%0d e=%b r=%h f=%b exp 1 3 1 0 0000",
                  rsp_valid, rsp_id, rsp_err, rsp_result, rsp_flags);
      end
      checks++;
      if (req_ready !== 4'b0001) begin
         errors++; $display("FAIL illegal_ptr got %b exp 0001", req_ready);
      end
      req_valid = '0;
      step();
   endtask

   task automatic test_reset_mid();
      rsp_ready = 1'b0;
      set_req(1, 64'd7, 64'd8, 3'b101);
      req_valid = 4'b0010;
      step();                                   // FULL with id 1, ptr -> 2
      req_valid = 4'b1111;
      reset = 1'b1;
      rsp_ready = 1'b1;
      #1;
      checks++;
      if (req_ready !== 4'b0000) begin
         errors++; $display("FAIL rstmid_ready got %b exp 0000", req_ready);
      end
      step();
      #1;
      checks++;
      if (rsp_valid !== 1'b0 || rsp_result !== 64'd0) begin
         errors++;
         $display("FAIL rstmid_flush got v=%b r=%h exp 0 0", rsp_valid, rsp_result);
      end
      reset = 1'b0;
      #1;
      checks++;
      if (req_ready !== 4'b0001) begin
         errors++; $display("FAIL rstmid_first got %b exp 0001", req_ready);
      end
      step();
      req_valid = '0;
      #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_result !== 64'd2) begin
         errors++;
         $display("FAIL rstmid_rsp got v=%b id=%0d r=%0d exp 1 0 2",
                  rsp_valid, rsp_id, rsp_result);
      end
   endtask

   initial begin
      reset = 1'b1;
      req_valid = '0;
      req_a = '0;
      req_b = '0;
      req_cntrl = '0;
      rsp_ready = 1'b0;
      step();
      test_reset();
      test_single_op();
      test_round_robin();
      test_backpressure();
      test_flags();
      test_illegal();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one 64-bit ripple-carry ALU (alu_64bit) among NREQ requesters, e.g. execute stage and address-generation unit.
- Round-robin grant, valid/ready handshake on the request side, and a one-entry registered response buffer with backpressure.
- Throughput is one operation per cycle; latency is one cycle from accept to response.
- Sits between the requesters and the ALU instance, which it contains.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, $clog2(NREQ), width of the requester ID.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  per-requester request valid.
- req_a  input  NREQ*64  operand A, requester i at [64*i+63:64*i].
- req_b  input  NREQ*64  operand B, same packing as req_a.
- req_cntrl  input  NREQ*3  ALU op code, requester i at [3*i+2:3*i].
- req_ready  output  NREQ  one-hot grant; combinational; the transfer happens at the edge where valid and ready are both 1.
- rsp_valid  output  1  response buffer holds a result.
- rsp_ready  input  1  consumer accepts the response.
- rsp_id  output  IDW  index of the requester that owns the response.
- rsp_result  output  64  ALU result.
- rsp_flags  output  4  {negative, zero, overflow, carry_out}.
- rsp_err  output  1  the accepted op code was illegal.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high. All outputs except req_ready are registered.
- Reset values: rsp_valid=0, rsp_id=0, rsp_result=0, rsp_flags=0, rsp_err=0. Round-robin pointer ptr=0, so requester 0 has first priority. req_ready=0 while reset is high.
- Legal op codes: 000 pass B, 010 A+B, 011 A-B, 100 AND, 101 OR, 110 XOR. 001 and 111 are illegal.
- Response-buffer FSM has two states:
  - EMPTY: rsp_valid=0.
  - FULL: rsp_valid=1.
  - can_issue = EMPTY, or (FULL and rsp_ready).
- Grant: when can_issue is 1, g = the first i with req_valid[i]=1, searching ptr, ptr+1, ... mod NREQ. req_ready[g]=1 and all other bits are 0. If no requester is valid, or can_issue=0, req_ready=0.
- Datapath: the ALU inputs are muxed from requester g (operands and cntrl). When there is no grant, the ALU is driven with A=0, B=0, cntrl=000.
- On a grant edge:
  - rsp_result and rsp_flags capture the ALU outputs; rsp_id=g; rsp_err=0; state goes to FULL.
  - ptr becomes (g+1) mod NREQ.
  - A pop and a grant in the same cycle replace the buffer contents with no bubble.
- Illegal op: the request is still accepted and ptr still advances. rsp_err=1, rsp_result=0, rsp_flags=0.
- Pop without grant: rsp_valid=1, rsp_ready=1 and no grant moves the state to EMPTY. rsp_result, rsp_flags and rsp_id hold their values.
- Backpressure: while FULL and rsp_ready=0, all response outputs and ptr hold, and req_ready=0.
- Requester obligation: a requester holds its operands and cntrl stable while req_valid=1 and req_ready=0. Withdrawing a request before grant is allowed.
- Flags: come from the ALU unchanged and are meaningful only for ops 010 and 011. For other legal ops, negative and zero are meaningful; carry_out and overflow are captured raw.
- Reset in mid-operation: a pending response is discarded. No grant is issued in the reset cycle.
- Timing: the clock period must exceed the ripple path of alu_64bit. The bench uses a 50 ns period.

Decomposition:
- Package alu_pkg:
  - op code localparams ALU_PASSB=3'b000, ALU_ADD=3'b010, ALU_SUB=3'b011, ALU_AND=3'b100, ALU_OR=3'b101, ALU_XOR=3'b110;
  - function op_legal(cntrl);
  - flag bit index constants FLAG_N=3, FLAG_Z=2, FLAG_V=1, FLAG_C=0.
- Sub-module rr_arbiter: combinational one-hot grant from req_valid, ptr and enable, plus the pointer register, parameterised by NREQ. The top level holds the operand mux, the alu_64bit instance and the response buffer.

Test Plan:
1. Single op: req_valid=0001, A=7FFFFFFFFFFFFFFF, B=1, cntrl=010 -> req_ready=0001 in the same cycle. Next cycle rsp_valid=1, rsp_id=0, rsp_result=8000000000000000, flags=1010.
2. Round-robin: all 4 requesters valid continuously with rsp_ready=1 -> grants go 0,1,2,3,0, one per cycle, and the rsp_id sequence matches with no bubbles.
3. Backpressure: response FULL, rsp_ready=0 for 3 cycles with requesters 1 and 2 valid -> req_ready=0 and outputs stable for 3 cycles. When rsp_ready=1, requester 1 is granted (ptr order), then requester 2.
4. Flags: subtract with A=4, B=5 -> result FFFFFFFFFFFFFFFF, flags=1000. Subtract with A=10, B=10 -> result 0, flags=0101.
5. Illegal op: cntrl=111 from requester 3 -> accepted, rsp_err=1, rsp_result=0, flags=0000, ptr advances to 0.
6. Reset mid-stream: reset high while FULL with requests pending -> next cycle rsp_valid=0, req_ready=0, ptr=0. After reset is released, requester 0 is granted first.
